// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every stim vector of a combinational
// block and folds its responses into a rotate/XOR signature and a ones count.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN:0]    ones_count
);

    localparam int CW = N_IN + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_IN-1:0]  stim_nx;
    logic [SIG_W-1:0] sig_nx;
    logic [N_IN:0]    ones_nx;
    logic             busy_nx;
    logic             done_nx;

    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] sig_rot;
    logic [N_IN:0]    ones_inc;
    logic             last_vec;

    assign resp_ext = SIG_W'(resp);
    assign sig_rot  = {signature[SIG_W-2:0], signature[SIG_W-1]};
    assign ones_inc = CW'(resp[0]);
    assign last_vec = &stim;

    always_comb begin
        state_nx = state;
        stim_nx  = stim;
        sig_nx   = signature;
        ones_nx  = ones_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    stim_nx  = '0;
                    sig_nx   = '0;
                    ones_nx  = '0;
                end
            end
            RUN: begin
                // hold freezes everything, including the response sample
                if (!hold) begin
                    sig_nx  = sig_rot ^ resp_ext;
                    ones_nx = ones_count + ones_inc;
                    if (last_vec) begin
                        state_nx = FINISH;
                    end else begin
                        stim_nx = stim + N_IN'(1);
                    end
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stim       <= '0;
            signature  <= '0;
            ones_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            stim       <= stim_nx;
            signature  <= sig_nx;
            ones_count <= ones_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: random truth tables and holds
// compared against a table-walking fold model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance: table-driven response
    logic       start_m = 1'b0;
    logic       hold_m  = 1'b0;
    logic [1:0] resp_m;
    logic [3:0] stim_m;
    logic       busy_m;
    logic       done_m;
    logic [15:0] sig_m;
    logic [4:0] ones_m;
    logic [1:0] tt [16];

    assign resp_m = tt[stim_m];

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SIG_W(16)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .hold(hold_m),
        .resp(resp_m), .stim(stim_m), .busy(busy_m), .done(done_m),
        .signature(sig_m), .ones_count(ones_m)
    );

    // 2-input XOR instance
    logic        start_s = 1'b0;
    logic [0:0]  resp_s;
    logic [1:0]  stim_s;
    logic        busy_s;
    logic        done_s;
    logic [15:0] sig_s;
    logic [2:0]  ones_s;

    assign resp_s = stim_s[1] ^ stim_s[0];

    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .SIG_W(16)) dut_x (
        .clk(clk), .rst(rst), .start(start_s), .hold(1'b0),
        .resp(resp_s), .stim(stim_s), .busy(busy_s), .done(done_s),
        .signature(sig_s), .ones_count(ones_s)
    );

    // 3-input instance, 8-bit signature
    logic [0:0] resp_j;
    logic [2:0] stim_j;
    logic       busy_j;
    logic       done_j;
    logic [7:0] sig_j;
    logic [3:0] ones_j;

    assign resp_j = (stim_j[2] & stim_j[0]) | (stim_j[1] & ~stim_j[0])
                  | (stim_j[2] & stim_j[1]);

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SIG_W(8)) dut_j (
        .clk(clk), .rst(rst), .start(start_s), .hold(1'b0),
        .resp(resp_j), .stim(stim_j), .busy(busy_j), .done(done_j),
        .signature(sig_j), .ones_count(ones_j)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // signature model: fold each response in vector order
    function automatic bit [31:0] fold(input int vals[$], input int w);
        bit [31:0] s;
        bit [31:0] mask;
        s = 0;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
        foreach (vals[i]) begin
            s = (((s << 1) | (s >> (w - 1))) & mask) ^ vals[i];
        end
        return s;
    endfunction

    task automatic rand_table();
        for (int v = 0; v < 16; v++) tt[v] = 2'($urandom_range(0, 3));
    endtask

    task automatic sweep(input string tag, input int hold_at,
                         input int hold_len, input bit restart);
        int vals[$];
        int ones;
        int cyc;
        int held;
        int busy_n;
        int exp_stim;
        int stim_bad;
        bit h;
        logic [15:0] exp_sig;
        ones = 0;
        for (int v = 0; v < 16; v++) begin
            vals.push_back(int'(tt[v]));
            ones += int'(tt[v][0]);
        end
        exp_sig = 16'(fold(vals, 16));
        @(negedge clk);
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        check($sformatf("%s_go", tag),
              {busy_m, done_m, stim_m, sig_m, ones_m},
              {1'b1, 1'b0, 4'd0, 16'd0, 5'd0});
        cyc = 0;
        held = 0;
        busy_n = 1;
        exp_stim = 0;
        stim_bad = 0;
        while (!done_m && cyc < 100) begin
            @(negedge clk);
            h = (exp_stim == hold_at) && (held < hold_len);
            hold_m = h;
            start_m = restart && (cyc == 3 || cyc == 10);
            @(posedge clk);
            #1;
            cyc++;
            if (h) held++;
            else if (exp_stim != 15) exp_stim++;
            if (busy_m) busy_n++;
            if (stim_m !== 4'(exp_stim)) stim_bad++;
        end
        hold_m = 1'b0;
        start_m = 1'b0;
        check($sformatf("%s_done", tag), done_m, 1);
        check($sformatf("%s_stimseq", tag), stim_bad, 0);
        check($sformatf("%s_lat", tag), cyc, 16 + hold_len);
        check($sformatf("%s_busyn", tag), busy_n, 16 + hold_len);
        check($sformatf("%s_sig", tag), sig_m, exp_sig);
        check($sformatf("%s_ones", tag), ones_m, ones);
        @(posedge clk);
        #1;
        check($sformatf("%s_post", tag), {busy_m, done_m, stim_m},
              {1'b0, 1'b0, 4'hF});
        check($sformatf("%s_keep", tag), {sig_m, ones_m},
              {exp_sig, 5'(ones)});
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s_idle", tag), {busy_m, done_m}, 0);
    endtask

    initial begin
        int cyc;
        int dn_s;
        int dn_j;
        int bz_s;
        int bz_j;
        int seq_bad;
        int seen_done;
        int mvals[$];

        for (int v = 0; v < 16; v++) tt[v] = 2'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m", {busy_m, done_m, stim_m, sig_m, ones_m}, 0);
        check("rst_x", {busy_s, done_s, stim_s, sig_s, ones_s}, 0);
        @(negedge clk);
        rst = 1'b0;

        // small fixed-function sweeps
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        dn_s = 0;
        dn_j = 0;
        bz_s = 0;
        bz_j = 0;
        seq_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 4 && stim_s !== 2'(k)) seq_bad++;
            if (k < 8 && stim_j !== 3'(k)) seq_bad++;
            if (done_s) begin
                dn_s++;
                if (k != 4) seq_bad++;
            end
            if (done_j) begin
                dn_j++;
                if (k != 8) seq_bad++;
            end
            if (busy_s) bz_s++;
            if (busy_j) bz_j++;
            @(posedge clk);
            #1;
        end
        check("x_seq", seq_bad, 0);
        check("x_dones", dn_s, 1);
        check("x_busy", bz_s, 4);
        check("x_sig", sig_s, 16'h0006);
        check("x_ones", ones_s, 2);
        for (int v = 0; v < 8; v++) begin
            mvals.push_back(((v >> 2) & v & 1) | ((v >> 1) & ~v & 1)
                            | ((v >> 2) & (v >> 1) & 1));
        end
        check("j_dones", dn_j, 1);
        check("j_busy", bz_j, 8);
        check("j_ones", ones_j, 4);
        check("j_sig", sig_j, 8'(fold(mvals, 8)));

        // main sweeps
        rand_table();
        sweep("plain", 99, 0, 1'b0);
        sweep("hold3", 1, 3, 1'b0);
        sweep("restart", 99, 0, 1'b1);

        // reset mid-sweep, with start and hold also high
        rand_table();
        @(negedge clk);
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        cyc = 0;
        while (stim_m !== 4'd2 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_reach", stim_m, 2);
        @(negedge clk);
        rst = 1'b1;
        start_m = 1'b1;
        hold_m = 1'b1;
        @(posedge clk);
        #1;
        check("midrst", {busy_m, done_m, stim_m, sig_m, ones_m}, 0);
        @(negedge clk);
        rst = 1'b0;
        start_m = 1'b0;
        hold_m = 1'b0;
        seen_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done_m || busy_m) seen_done++;
        end
        check("midrst_quiet", seen_done, 0);
        sweep("after_rst", 99, 0, 1'b0);

        for (int v = 0; v < 16; v++) tt[v] = 2'd1;
        sweep("const1", 99, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_table();
            sweep($sformatf("rnd%0d", r), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 4: number of stimulus bits driven to the combinational circuit under test; legal range 1..16.
REQ-002 Parameter N_OUT, default 1: number of response bits returned by the circuit under test; legal range 1..SIG_W.
REQ-003 Parameter SIG_W, default 16: signature register width; legal range 2..32.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  request a full truth-table sweep; sampled only in IDLE.
REQ-007 hold  input  1  pause the sweep; while high in RUN, no state advances.
REQ-008 resp  input  N_OUT  combinational response of the circuit under test to the current stim.
REQ-009 stim  output  N_IN  current input vector; bit N_IN-1 is the most significant input (first-listed variable).
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  single-cycle pulse marking sweep completion.
REQ-012 signature  output  SIG_W  compacted response signature.
REQ-013 ones_count  output  N_IN+1  number of vectors for which resp[0] was 1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and FINISH; outputs are registered.
REQ-015 IDLE with start=1 at an edge SHALL go to RUN with stim=0, signature=0 and ones_count=0; IDLE with start=0 SHALL stay in IDLE.
REQ-016 RUN with hold=0 at each edge SHALL sample resp against the current stim and update signature and ones_count.
REQ-017 After that update, if stim equals all-ones, the FSM SHALL go to FINISH with stim unchanged; otherwise stim SHALL increment by 1.
REQ-018 RUN with hold=1 SHALL leave stim, signature, ones_count and state unchanged, and resp SHALL be ignored.
REQ-019 Signature update: sig_next = (signature rotated left by 1) XOR (resp zero-extended to SIG_W).
REQ-020 ones_count SHALL increment by 1 on each sampled vector with resp[0]=1; its width holds 2^N_IN without overflow.
REQ-021 FINISH SHALL assert done for exactly one cycle and return to IDLE at the next edge.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and FINISH.
REQ-023 Latency: with hold held low, done SHALL be high in the cycle following the 2^N_IN-th RUN edge after the start-accepting edge.
REQ-024 start asserted in RUN or FINISH SHALL be ignored; no restart and no queued request.
REQ-025 signature, ones_count and stim SHALL hold their final values after FINISH until the next accepted start.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, stim=0, signature=0, ones_count=0, busy=0 and done=0, regardless of state.
REQ-027 rst SHALL take priority over start and hold in the same cycle.
REQ-028 rst asserted mid-RUN SHALL abort the sweep with no done pulse.

Verification
REQ-029 N_IN=2, N_OUT=1, resp=stim[1]^stim[0], one-cycle start -> stim 0,1,2,3 on consecutive cycles; done pulses once, 4 cycles after the start edge; signature=0x0006; ones_count=2.
REQ-030 N_IN=3, resp=(s2&s0)|(s1&~s0)|(s2&s1) with s2 the MSB -> ones_count=4; busy high for exactly 8 cycles.
REQ-031 Previous sweep with hold=1 for 3 cycles at stim=1 -> stim stays 1 for 4 cycles total; final signature and ones_count are identical to the no-hold run; done is delayed by 3 cycles.
REQ-032 start pulsed again while busy=1 -> ignored; exactly one done pulse; results unchanged.
REQ-033 rst asserted at stim=2 during a sweep -> next cycle is IDLE with all outputs 0 and no done; a subsequent start performs a full, correct sweep.
REQ-034 N_IN=4, resp=1 constant -> ones_count=16; signature equals the 16-step rotate/XOR fold of 1 computed by the reference model.
